// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Function : CPU/debug arbiter and 3-cycle sequencer for a shared 256x16 RAM.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
   parameter int MAX_WAIT = 4,
   parameter int AW       = 9
) (
   input  logic          clk,
   input  logic          reset,

   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [15:0]   cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [15:0]   cpu_rdata,

   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [15:0]   dbg_wdata,
   output logic          dbg_gnt,
   output logic          dbg_rvalid,
   output logic [15:0]   dbg_rdata,

   output logic [AW-2:0] mem_addr,
   output logic          mem_we,
   output logic [15:0]   mem_din,
   input  logic [15:0]   mem_dout,

   output logic          bad_addr,
   output logic          busy
);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_ACCESS = 2'd1;
   localparam logic [1:0] c_RESP   = 2'd2;

   localparam int                  c_WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);

   logic [1:0]          r_state;
   logic                r_owner;   // 0 = CPU, 1 = debug
   logic                r_we;
   logic [AW-1:0]       r_addr;
   logic [15:0]         r_wdata;
   logic [c_WAIT_W-1:0] r_wait;
   logic                r_bad;

   logic                w_dbg_wins;
   logic                w_access;
   logic                w_resp;
   logic                w_in_range;
   logic [15:0]         w_rdata;

   // Debug wins when alone, or when the CPU has used up its contended wins.
   always_comb begin
      w_dbg_wins = 1'b0;
      if (dbg_req && !cpu_req) begin
         w_dbg_wins = 1'b1;
      end else if (dbg_req && cpu_req && (r_wait >= c_WAIT_MAX)) begin
         w_dbg_wins = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_IDLE;
         r_owner <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wait  <= '0;
         r_bad   <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (cpu_req || dbg_req) begin
                  r_owner <= w_dbg_wins;
                  r_we    <= w_dbg_wins ? dbg_we    : cpu_we;
                  r_addr  <= w_dbg_wins ? dbg_addr  : cpu_addr;
                  r_wdata <= w_dbg_wins ? dbg_wdata : cpu_wdata;
                  r_state <= c_ACCESS;
                  if (w_dbg_wins) begin
                     r_wait <= '0;
                  end else if (dbg_req) begin
                     r_wait <= r_wait + 1'b1;
                  end
               end
            end
            c_ACCESS: begin
               if (r_addr[AW-1]) begin
                  r_bad <= 1'b1;
               end
               r_state <= c_RESP;
            end
            c_RESP: begin
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   // Outputs are masked by reset so an in-flight write cannot reach the RAM.
   assign w_access   = !reset && (r_state == c_ACCESS);
   assign w_resp     = !reset && (r_state == c_RESP);
   assign w_in_range = !r_addr[AW-1];
   assign w_rdata    = (!r_we && w_in_range) ? mem_dout : 16'h0000;

   assign mem_addr   = w_access ? r_addr[AW-2:0] : '0;
   assign mem_din    = w_access ? r_wdata : 16'h0000;
   assign mem_we     = w_access && r_we && w_in_range;

   assign cpu_gnt    = w_access && !r_owner;
   assign dbg_gnt    = w_access &&  r_owner;
   assign cpu_rvalid = w_resp   && !r_owner;
   assign dbg_rvalid = w_resp   &&  r_owner;
   assign cpu_rdata  = cpu_rvalid ? w_rdata : 16'h0000;
   assign dbg_rdata  = dbg_rvalid ? w_rdata : 16'h0000;

   assign busy       = w_access || w_resp;
   assign bad_addr   = r_bad && !reset;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Function : Directed and randomised bench for mem_arbiter with a RAM model.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

   localparam int c_MAX_WAIT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [8:0]  cpu_addr, dbg_addr;
   logic [15:0] cpu_wdata, dbg_wdata;
   logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [15:0] cpu_rdata, dbg_rdata;
   logic [7:0]  mem_addr;
   logic        mem_we;
   logic [15:0] mem_din, mem_dout;
   logic        bad_addr, busy;

   logic        pre_en = 1'b0;
   logic [7:0]  pre_addr = '0;
   logic [15:0] pre_data = '0;
   logic [15:0] ram [256];
   logic [15:0] shadow [256];

   int   compared   = 0;
   int   mismatched = 0;
   int   wait_cnt   = 0;
   logic bad_exp    = 1'b0;

   mem_arbiter #(.MAX_WAIT(c_MAX_WAIT), .AW(9)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
      .bad_addr(bad_addr), .busy(busy)
   );

   always #5 clk = ~clk;

   // Single-port RAM with one-cycle registered read; pre_* is a bench-only load port.
   always @(posedge clk) begin
      mem_dout <= ram[mem_addr];
      if (pre_en) ram[pre_addr] = pre_data;
      else if (mem_we) ram[mem_addr] = mem_din;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered 1 time unit after an edge with the DUT idle; leaves it idle again.
   task automatic run_txn(input logic cr, input logic cw, input logic [8:0] ca, input logic [15:0] cd,
                          input logic dr, input logic dw, input logic [8:0] da, input logic [15:0] dd,
                          output logic won_dbg, output logic [15:0] rd);
      logic        w;
      logic        we_e;
      logic [8:0]  a_e;
      logic [15:0] d_e, rd_e;
      check("idle_busy", busy, 0);
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
      if (cr && dr) begin
         if (wait_cnt < c_MAX_WAIT) begin w = 1'b0; wait_cnt++; end
         else begin w = 1'b1; wait_cnt = 0; end
      end else if (dr) begin
         w = 1'b1; wait_cnt = 0;
      end else begin
         w = 1'b0;
      end
      we_e = w ? dw : cw;
      a_e  = w ? da : ca;
      d_e  = w ? dd : cd;

      @(posedge clk); #1;
      check("acc_cpu_gnt", cpu_gnt, !w);
      check("acc_dbg_gnt", dbg_gnt, w);
      check("acc_busy", busy, 1);
      check("acc_mem_we", mem_we, we_e && !a_e[8]);
      check("acc_mem_addr", mem_addr, a_e[7:0]);
      check("acc_mem_din", mem_din, d_e);
      check("acc_rvalid", {cpu_rvalid, dbg_rvalid}, 0);
      if (w) dbg_req = 1'b0; else cpu_req = 1'b0;

      @(posedge clk); #1;
      if (a_e[8]) bad_exp = 1'b1;
      rd_e = (!we_e && !a_e[8]) ? shadow[a_e[7:0]] : 16'h0000;
      if (we_e && !a_e[8]) shadow[a_e[7:0]] = d_e;
      check("rsp_cpu_rvalid", cpu_rvalid, !w);
      check("rsp_dbg_rvalid", dbg_rvalid, w);
      check("rsp_cpu_rdata", cpu_rdata, w ? 16'h0000 : rd_e);
      check("rsp_dbg_rdata", dbg_rdata, w ? rd_e : 16'h0000);
      check("rsp_gnt", {cpu_gnt, dbg_gnt}, 0);
      check("rsp_mem_we", mem_we, 0);
      check("rsp_mem_addr", mem_addr, 0);
      check("rsp_bad_addr", bad_addr, bad_exp);
      rd = w ? dbg_rdata : cpu_rdata;
      won_dbg = w;

      @(posedge clk); #1;
   endtask

   initial begin
      logic        wd;
      logic [15:0] rd;
      logic [5:0]  order, order_exp;
      logic [1:0]  r;
      logic [15:0] v;

      reset = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h014; cpu_wdata = '0;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h015; dbg_wdata = 16'h1111;

      for (int i = 0; i < 256; i++) begin
         @(posedge clk); #1;
         v = (i == 8'h14) ? 16'd850 : 16'($urandom);
         pre_en = 1'b1; pre_addr = 8'(i); pre_data = v; shadow[i] = v;
      end
      @(posedge clk); #1;
      pre_en = 1'b0;

      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check("rst_gnt", {cpu_gnt, dbg_gnt}, 0);
         check("rst_rvalid", {cpu_rvalid, dbg_rvalid}, 0);
         check("rst_rdata", {cpu_rdata, dbg_rdata}, 0);
         check("rst_mem", {mem_addr, mem_we, mem_din}, 0);
         check("rst_flags", {bad_addr, busy}, 0);
      end
      reset = 1'b0;

      // First arbitration after reset with both requesting goes to the CPU.
      run_txn(1, 0, 9'h014, 16'h0, 1, 1, 9'h015, 16'h1111, wd, rd);
      check("first_gnt_cpu", wd, 0);
      check("first_rdata", rd, 16'h0352);
      dbg_req = 1'b0;

      run_txn(1, 0, 9'h014, 16'h0, 0, 0, 9'h0, 16'h0, wd, rd);
      check("cpu_read_rdata", rd, 16'h0352);

      run_txn(0, 0, 9'h0, 16'h0, 1, 1, 9'h015, 16'hBADD, wd, rd);
      check("dbg_write_owner", wd, 1);
      run_txn(1, 0, 9'h015, 16'h0, 0, 0, 9'h0, 16'h0, wd, rd);
      check("read_back_badd", rd, 16'hBADD);

      order_exp = 6'b100100;
      for (int i = 0; i < 6; i++) begin
         run_txn(1, 0, 9'(8'($urandom)), 16'h0, 1, 0, 9'(8'($urandom)), 16'h0, wd, rd);
         order[i] = wd;
      end
      check("starve_order", order, order_exp);
      cpu_req = 1'b0; dbg_req = 1'b0;

      run_txn(1, 1, 9'h100, 16'h5A5A, 0, 0, 9'h0, 16'h0, wd, rd);
      check("oob_rdata", rd, 0);
      check("oob_bad_sticky", bad_addr, 1);
      run_txn(1, 0, 9'h014, 16'h0, 0, 0, 9'h0, 16'h0, wd, rd);
      check("after_oob_read", rd, 16'h0352);
      check("after_oob_bad", bad_addr, 1);

      for (int i = 0; i < 40; i++) begin
         r = 2'($urandom_range(0, 3));
         if (r == 2'b00) begin
            cpu_req = 1'b0; dbg_req = 1'b0;
            @(posedge clk); #1;
            check("idle_stay", {busy, cpu_gnt, dbg_gnt}, 0);
         end else begin
            run_txn(r[0], 1'($urandom), {($urandom_range(0, 7) == 0), 8'($urandom)}, 16'($urandom),
                    r[1], 1'($urandom), {($urandom_range(0, 7) == 0), 8'($urandom)}, 16'($urandom),
                    wd, rd);
         end
      end
      cpu_req = 1'b0; dbg_req = 1'b0;
      @(posedge clk); #1;

      // Reset lands in the ACCESS cycle of a debug write.
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h010; dbg_wdata = ~shadow[8'h10];
      @(posedge clk); #1;
      check("mid_gnt", dbg_gnt, 1);
      reset = 1'b1; dbg_req = 1'b0;
      #1;
      check("mid_mem_we", mem_we, 0);
      check("mid_outputs", {dbg_gnt, busy}, 0);
      @(posedge clk); #1;
      check("mid_rvalid", {dbg_rvalid, cpu_rvalid}, 0);
      check("mid_bad", bad_addr, 0);
      reset = 1'b0;
      wait_cnt = 0; bad_exp = 1'b0;
      @(posedge clk); #1;
      check("post_rst_idle", {busy, cpu_gnt, dbg_gnt}, 0);
      check("mem10_intact", ram[8'h10], shadow[8'h10]);
      run_txn(1, 0, 9'h010, 16'h0, 0, 0, 9'h0, 16'h0, wd, rd);
      check("mem10_read", rd, shadow[8'h10]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
